// File: rtl/switch_oq_fifo.sv
// Store-and-forward output-queue FIFO for one switch port; drops overflowing or bad frames.
// Optional per-port frame counters are enabled with the SWITCH_OQ_STATS_EN macro.
module switch_oq_fifo #(
   parameter int DEPTH = 4096,
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH = 8,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 17,
   parameter logic [USER_WIDTH-1:0] USER_BAD_MASK = USER_WIDTH'(1),
   parameter logic [USER_WIDTH-1:0] USER_BAD_VALUE = USER_WIDTH'(1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   input  logic [ID_WIDTH-1:0]      s_axis_tid,
   input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
   input  logic [USER_WIDTH-1:0]    s_axis_tuser,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [ID_WIDTH-1:0]      m_axis_tid,
   output logic [DEST_WIDTH-1:0]    m_axis_tdest,
   output logic [USER_WIDTH-1:0]    m_axis_tuser,
   output logic [$clog2(DEPTH):0]   status_depth,
   output logic                     status_overflow,
   output logic                     status_bad_frame,
   output logic                     status_good_frame
`ifdef SWITCH_OQ_STATS_EN
   ,
   output logic [31:0]              stat_good_frames,
   output logic [31:0]              stat_overflow_frames,
   output logic [31:0]              stat_bad_frames
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PW = ADDR_W + 1;
   localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1
                         + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] in_word;
   logic [WORD_W-1:0] ram_q;
   logic [WORD_W-1:0] out_q;

   logic [PW-1:0] wr_cur_q, wr_cur_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   logic drop_q, drop_d;
   logic rdy_q;
   logic ovf_q, ovf_d;
   logic bad_q, bad_d;
   logic good_q, good_d;
   logic ram_vld_q, ram_vld_d;
   logic out_vld_q, out_vld_d;

   logic full;
   logic empty;
   logic acc;
   logic is_bad;
   logic wr_en;
   logic rd_en;
   logic out_rdy;
   logic ram_rdy;

   assign in_word = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                     s_axis_tid, s_axis_tdest, s_axis_tuser};

   // Full looks at the speculative pointer; empty only at committed frames.
   assign full = (wr_cur_q - rd_ptr_q) == PW'(DEPTH);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign acc = s_axis_tvalid & rdy_q;
   assign is_bad = (s_axis_tuser & USER_BAD_MASK) == USER_BAD_VALUE;

   always_comb begin
      wr_cur_d = wr_cur_q;
      wr_ptr_d = wr_ptr_q;
      drop_d = drop_q;
      ovf_d = 1'b0;
      bad_d = 1'b0;
      good_d = 1'b0;
      wr_en = 1'b0;
      if (acc) begin
         if (full || drop_q) begin
            drop_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            wr_cur_d = wr_cur_q + PW'(1);
         end
         if (s_axis_tlast) begin
            if (drop_q || full) begin
               wr_cur_d = wr_ptr_q;
               drop_d = 1'b0;
               ovf_d = 1'b1;
            end else if (is_bad) begin
               wr_cur_d = wr_ptr_q;
               bad_d = 1'b1;
            end else begin
               wr_ptr_d = wr_cur_q + PW'(1);
               good_d = 1'b1;
            end
         end
      end
   end

   // Two-stage read pipeline: RAM data register, then output register.
   always_comb begin
      out_rdy = !out_vld_q || m_axis_tready;
      ram_rdy = !ram_vld_q || out_rdy;
      rd_en = !empty && ram_rdy;
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
      ram_vld_d = ram_rdy ? rd_en : ram_vld_q;
      out_vld_d = out_rdy ? ram_vld_q : out_vld_q;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_cur_q[ADDR_W-1:0]] <= in_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
      end
      if (out_rdy && ram_vld_q) begin
         out_q <= ram_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cur_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q <= 1'b0;
         rdy_q <= 1'b0;
         ovf_q <= 1'b0;
         bad_q <= 1'b0;
         good_q <= 1'b0;
         ram_vld_q <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         wr_cur_q <= wr_cur_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q <= drop_d;
         rdy_q <= 1'b1;
         ovf_q <= ovf_d;
         bad_q <= bad_d;
         good_q <= good_d;
         ram_vld_q <= ram_vld_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign s_axis_tready = rdy_q;
   assign m_axis_tvalid = out_vld_q;
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
           m_axis_tid, m_axis_tdest, m_axis_tuser} = out_q;

   assign status_depth = (wr_ptr_q - rd_ptr_q)
                       + PW'(ram_vld_q) + PW'(out_vld_q);
   assign status_overflow = ovf_q;
   assign status_bad_frame = bad_q;
   assign status_good_frame = good_q;

`ifdef SWITCH_OQ_STATS_EN
   logic [31:0] n_good_q;
   logic [31:0] n_ovf_q;
   logic [31:0] n_bad_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_good_q <= '0;
         n_ovf_q <= '0;
         n_bad_q <= '0;
      end else begin
         n_good_q <= n_good_q + 32'(good_q);
         n_ovf_q <= n_ovf_q + 32'(ovf_q);
         n_bad_q <= n_bad_q + 32'(bad_q);
      end
   end

   assign stat_good_frames = n_good_q;
   assign stat_overflow_frames = n_ovf_q;
   assign stat_bad_frames = n_bad_q;
`else
`endif

endmodule
